// File: rtl/risc_pkg.sv
// Shared definitions for the 4-bit RISC core: widths, opcode constants and
// the fetch state encoding.
package risc_pkg;

    localparam int PC_W    = 4;
    localparam int INSTR_W = 8;

    localparam logic [3:0] OP_LOAD  = 4'b0001;
    localparam logic [3:0] OP_STORE = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_OR    = 4'b0110;
    localparam logic [3:0] OP_NOT   = 4'b0111;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LATCH,
        ST_ISSUE,
        ST_HALTED
    } fetch_state_t;

    function automatic logic is_halt(input logic [3:0] op);
        return op == OP_HALT;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction memory port, issue handshake toward the control
// unit, redirect/resume controls and status.
interface fetch_unit_if #(
    parameter int PC_W    = risc_pkg::PC_W,
    parameter int INSTR_W = risc_pkg::INSTR_W
) ();
    logic [PC_W-1:0]      imem_addr;
    logic                 imem_en;
    logic [INSTR_W-1:0]   imem_rdata;
    logic [3:0]           opcode;
    logic [INSTR_W-5:0]   operand;
    logic                 instr_valid;
    logic                 exec_ready;
    logic                 jump_en;
    logic [PC_W-1:0]      jump_addr;
    logic                 resume;
    logic [PC_W-1:0]      pc;
    logic                 halted;

    modport master (
        output imem_addr, imem_en,
        input  imem_rdata,
        output opcode, operand, instr_valid,
        input  exec_ready, jump_en, jump_addr, resume,
        output pc, halted
    );

    modport slave (
        input  imem_addr, imem_en,
        output imem_rdata,
        input  opcode, operand, instr_valid,
        output exec_ready, jump_en, jump_addr, resume,
        input  pc, halted
    );
endinterface

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register: wrapping increment or parallel load, async clear.
module pc_reg #(
    parameter int PC_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            inc,
    input  logic            load,
    input  logic [PC_W-1:0] load_val,
    output logic [PC_W-1:0] pc
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= '0;
        end else if (load) begin
            pc <= load_val;
        end else if (inc) begin
            pc <= pc + PC_W'(1);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, instruction register, HALT detection and the
// valid/ready issue handshake toward the control unit.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | just out of reset, fetch starts on the next edge
// ST_FETCH  | memory read issued at pc
// ST_LATCH  | read data captured into IR, pc advances
// ST_ISSUE  | IR presented with instr_valid, waiting for exec_ready
// ST_HALTED | HALT accepted, fetching stopped until resume
module fetch_unit
    import risc_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);

    fetch_state_t       state;
    logic [INSTR_W-1:0] ir;
    logic [PC_W-1:0]    pc_q;
    logic               accept;
    logic               ir_halt;
    logic               pc_inc;
    logic               pc_load;

    assign ir_halt = is_halt(ir[INSTR_W-1 -: 4]);
    assign accept  = bus.instr_valid && bus.exec_ready;
    assign pc_inc  = (state == ST_LATCH);
    // HALT outranks a redirect, so a jump is loaded only for non-HALT acceptances
    assign pc_load = accept && !ir_halt && bus.jump_en;

    pc_reg #(.PC_W(PC_W)) u_pc_reg (
        .clk      (clk),
        .reset    (reset),
        .inc      (pc_inc),
        .load     (pc_load),
        .load_val (bus.jump_addr),
        .pc       (pc_q)
    );

    assign bus.pc        = pc_q;
    assign bus.imem_addr = pc_q;
    assign bus.opcode    = ir[INSTR_W-1 -: 4];
    assign bus.operand   = ir[INSTR_W-5:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= ST_IDLE;
            ir              <= '0;
            bus.imem_en     <= 1'b0;
            bus.instr_valid <= 1'b0;
            bus.halted      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state       <= ST_FETCH;
                    bus.imem_en <= 1'b1;
                end
                ST_FETCH: begin
                    state       <= ST_LATCH;
                    bus.imem_en <= 1'b0;
                end
                ST_LATCH: begin
                    ir              <= bus.imem_rdata;
                    state           <= ST_ISSUE;
                    bus.instr_valid <= 1'b1;
                end
                ST_ISSUE: begin
                    if (accept) begin
                        bus.instr_valid <= 1'b0;
                        if (ir_halt) begin
                            state      <= ST_HALTED;
                            bus.halted <= 1'b1;
                        end else begin
                            state       <= ST_FETCH;
                            bus.imem_en <= 1'b1;
                        end
                    end
                end
                ST_HALTED: begin
                    if (bus.resume) begin
                        state       <= ST_FETCH;
                        bus.halted  <= 1'b0;
                        bus.imem_en <= 1'b1;
                    end
                end
                default: begin
                    state           <= ST_IDLE;
                    bus.imem_en     <= 1'b0;
                    bus.instr_valid <= 1'b0;
                    bus.halted      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the 4-bit RISC core. It holds the program counter and reads 8-bit instructions from a synchronous-read instruction memory. It latches each instruction into an instruction register and presents the opcode and operand fields to the control unit through a valid/ready handshake. It detects the HALT opcode itself, stops fetching, and resumes only on an explicit pulse.

## Interface
- `PC_W`, 4, program counter / instruction memory address width
- `INSTR_W`, 8, instruction width; opcode = `[INSTR_W-1 -: 4]`, operand = `[INSTR_W-5:0]`
- `clk`  in  1  single clock, all state updates on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `imem_addr`  out  PC_W  instruction memory read address
- `imem_en`  out  1  memory read enable; memory samples `imem_addr` at the edge, returns data one cycle later
- `imem_rdata`  in  INSTR_W  memory read data
- `opcode`  out  4  opcode field of the instruction register
- `operand`  out  INSTR_W-4  operand field of the instruction register
- `instr_valid`  out  1  `opcode`/`operand` hold an instruction awaiting acceptance
- `exec_ready`  in  1  downstream accepts the instruction when high together with `instr_valid`
- `jump_en`  in  1  redirect request, sampled only on an accepted instruction
- `jump_addr`  in  PC_W  redirect target
- `resume`  in  1  single-cycle pulse that restarts fetching from HALTED
- `pc`  out  PC_W  current program counter
- `halted`  out  1  high while in HALTED

## Operation
- States: IDLE, FETCH, LATCH, ISSUE, HALTED.
- IDLE: entered on reset. Moves to FETCH on the next edge unconditionally.
- FETCH:
  - `imem_en`=1, `imem_addr`=`pc`.
  - Moves to LATCH.
- LATCH:
  - Instruction register <= `imem_rdata`.
  - `pc` <= `pc`+1, modulo 2^PC_W; 15 wraps to 0.
  - Moves to ISSUE.
- ISSUE:
  - `instr_valid`=1. The instruction register and `pc` are held stable until accepted.
  - Acceptance is `instr_valid && exec_ready`. On acceptance, in priority order:
    - opcode 4'b1111 (HALT) -> HALTED; `jump_en` is ignored.
    - else `jump_en` -> `pc` <= `jump_addr`, then FETCH.
    - else -> FETCH.
  - `exec_ready` low -> remain in ISSUE with no change to any output.
- HALTED:
  - `halted`=1, `instr_valid`=0, `imem_en`=0.
  - `pc` holds the address after the HALT instruction.
  - `resume`=1 -> FETCH from the current `pc`. `resume` is ignored in every other state.
- `imem_en` is high only in FETCH. `instr_valid` is high only in ISSUE.
- Reset at any time, including mid-ISSUE with `exec_ready` high, aborts the in-flight instruction. No acceptance is reported for the aborted instruction.
- Reset values, taking effect immediately:
  - state = IDLE
  - `pc` = 0
  - instruction register = 0, so `opcode` = 0 and `operand` = 0
  - `instr_valid` = 0, `imem_en` = 0, `halted` = 0
  - `imem_addr` = 0

## Timing
- Best-case throughput is one instruction per 3 cycles (FETCH, LATCH, ISSUE with `exec_ready` high).
- The first `instr_valid` rises 3 edges after reset deassertion (IDLE, FETCH, LATCH).
- Latency from acceptance to the next `instr_valid` is 3 edges.
- `pc` in ISSUE already points to the following instruction.
- A jump target is fetched in the FETCH cycle immediately after acceptance. There is no bubble beyond the normal sequence.
- `resume` to `instr_valid` is 3 edges.
- All outputs are decoded from registered state. There are no combinational paths from inputs to outputs.

## Structure
- Shared package `risc_pkg`:
  - opcode constants `OP_LOAD`=4'b0001, `OP_STORE`=4'b0010, `OP_ADD`=4'b0011, `OP_SUB`=4'b0100, `OP_AND`=4'b0101, `OP_OR`=4'b0110, `OP_NOT`=4'b0111, `OP_HALT`=4'b1111
  - fetch state enum `fetch_state_t`
- The control unit imports the same opcode constants.
- One sub-module, `pc_reg`:
  - PC_W-bit register with async reset to 0, increment (wrapping) and load inputs.
  - Increment and load are never asserted together; the FSM guarantees this.

## Test plan
- Reset then run, memory[0..2] = 8'h35, 8'h49, 8'hF0, `exec_ready` tied 1 -> the bench sees opcode/operand 3/5, then 4/9, then F/0, at 3-cycle spacing. After the third acceptance `halted`=1 and `pc`=3.
- Backpressure: hold `exec_ready`=0 for 5 cycles during ISSUE of 8'h35 -> `instr_valid` and `opcode`=3 stay stable with `pc`=1. `imem_en` stays 0. Acceptance occurs on the first cycle `exec_ready`=1.
- Jump: on accepting 8'h35 at address 0, assert `jump_en`=1 with `jump_addr`=4'hA -> the next `imem_addr` is A and the next `pc` in ISSUE is B.
- Wrap and halt priority:
  - HALT at address F accepted with `jump_en`=1, `jump_addr`=2 -> HALTED and `pc`=0.
  - `resume` pulse -> fetch from address 0.
  - `resume` pulsed in ISSUE -> no effect.
- Reset mid-operation: assert `reset` in ISSUE with `exec_ready`=1 -> all outputs return to reset values in the same cycle. After deassertion, the first fetch is from address 0.
